// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: pops bytes from the receiver FIFO, folds E0/F0
// prefixes into single key events, suppresses typematic repeats and maps to ASCII.
module ps2_scancode_decoder #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [7:0]         data,
  input  logic               ready,
  input  logic               overflow,
  output logic               nextdata_n,
  output logic               key_valid,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_break,
  output logic [7:0]         key_ascii,
  output logic               key_held,
  output logic [COUNT_W-1:0] key_count,
  output logic               overflow_seen
);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  state_t             state, state_d;
  logic               pend_ext, pend_ext_d;
  logic               pend_brk, pend_brk_d;
  logic               held_ext, held_ext_d;
  logic [7:0]         held_code, held_code_d;
  logic               nextdata_n_d, key_valid_d;
  logic [7:0]         key_code_d, key_ascii_d;
  logic               key_ext_d, key_break_d, key_held_d;
  logic [COUNT_W-1:0] key_count_d;
  logic               same_key_c;

  // Lowercase letters, digits, space, enter and backspace; everything else is 0x00.
  function automatic logic [7:0] ascii_of(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  assign same_key_c = ({pend_ext, data} == {held_ext, held_code});

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state         <= IDLE;
      pend_ext      <= 1'b0;
      pend_brk      <= 1'b0;
      held_ext      <= 1'b0;
      held_code     <= 8'h00;
      nextdata_n    <= 1'b1;
      key_valid     <= 1'b0;
      key_code      <= 8'h00;
      key_ext       <= 1'b0;
      key_break     <= 1'b0;
      key_ascii     <= 8'h00;
      key_held      <= 1'b0;
      key_count     <= '0;
      overflow_seen <= 1'b0;
    end else begin
      state         <= state_d;
      pend_ext      <= pend_ext_d;
      pend_brk      <= pend_brk_d;
      held_ext      <= held_ext_d;
      held_code     <= held_code_d;
      nextdata_n    <= nextdata_n_d;
      key_valid     <= key_valid_d;
      key_code      <= key_code_d;
      key_ext       <= key_ext_d;
      key_break     <= key_break_d;
      key_ascii     <= key_ascii_d;
      key_held      <= key_held_d;
      key_count     <= key_count_d;
      overflow_seen <= overflow_seen | overflow;
    end
  end

  // Handshake sequencing plus byte decode on the IDLE->POP transition.
  always_comb begin
    state_d      = state;
    pend_ext_d   = pend_ext;
    pend_brk_d   = pend_brk;
    held_ext_d   = held_ext;
    held_code_d  = held_code;
    nextdata_n_d = 1'b1;
    key_valid_d  = 1'b0;
    key_code_d   = key_code;
    key_ext_d    = key_ext;
    key_break_d  = key_break;
    key_ascii_d  = key_ascii;
    key_held_d   = key_held;
    key_count_d  = key_count;

    case (state)
      IDLE: begin
        if (ready) begin
          state_d      = POP;
          nextdata_n_d = 1'b0;
          case (data)
            8'hE0: pend_ext_d = 1'b1;
            8'hF0: pend_brk_d = 1'b1;
            8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFC, 8'hFE: begin
              pend_ext_d = 1'b0;
              pend_brk_d = 1'b0;
            end
            default: begin
              pend_ext_d = 1'b0;
              pend_brk_d = 1'b0;
              if (pend_brk) begin
                key_valid_d = 1'b1;
                key_code_d  = data;
                key_ext_d   = pend_ext;
                key_break_d = 1'b1;
                key_ascii_d = pend_ext ? 8'h00 : ascii_of(data);
                if (same_key_c) key_held_d = 1'b0;
              end else if (!(key_held && same_key_c)) begin
                key_valid_d = 1'b1;
                key_code_d  = data;
                key_ext_d   = pend_ext;
                key_break_d = 1'b0;
                key_ascii_d = pend_ext ? 8'h00 : ascii_of(data);
                held_ext_d  = pend_ext;
                held_code_d = data;
                key_held_d  = 1'b1;
                key_count_d = key_count + COUNT_W'(1);
              end
            end
          endcase
        end
      end
      POP:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with a behavioural receiver FIFO model.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;
  logic       overflow = 1'b0;
  logic       nextdata_n, key_valid, key_ext, key_break, key_held, overflow_seen;
  logic [7:0] key_code, key_ascii, key_count;

  ps2_scancode_decoder #(.COUNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .data(data), .ready(ready), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_break(key_break), .key_ascii(key_ascii),
    .key_held(key_held), .key_count(key_count), .overflow_seen(overflow_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
    logic       with_pop;
  } ev_t;

  logic [7:0] fifo[$];
  ev_t        evq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pulses = 0;
  int         last_pulse = -1;
  int         min_gap = 1000;
  bit         prev_low = 0;
  bit         bad_run = 0;

  // Receiver model and event recorder, evaluated away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (key_valid) evq.push_back('{key_code, key_ext, key_break, key_ascii, !nextdata_n});
    if (!nextdata_n) begin
      pulses++;
      if (prev_low) bad_run = 1;
      if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    prev_low = !nextdata_n;
    ready = (fifo.size() != 0);
    data  = ready ? fifo[0] : 8'h00;
  end

  task automatic do_reset();
    clrn = 1'b0;
    fifo.delete();
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    evq.delete();
    pulses = 0; last_pulse = -1; min_gap = 1000; prev_low = 0; bad_run = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (fifo.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: fifo still holds %0d bytes, required 0", fifo.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({nextdata_n, key_valid, key_code, key_ext, key_break, key_ascii, key_held, key_count, overflow_seen}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: ndn=%b kv=%b code=%h ext=%b brk=%b asc=%h held=%b cnt=%h ovf=%b",
               nextdata_n, key_valid, key_code, key_ext, key_break, key_ascii, key_held, key_count, overflow_seen);
    end
  endtask

  task automatic test_single_press();
    do_reset();
    fifo.push_back(8'h1C);
    drain();
    checks++;
    if (evq.size() != 1) begin
      errors++; $display("FAIL single_evcount: got %0d required 1", evq.size());
    end else begin
      checks++;
      if ({evq[0].code, evq[0].ascii, evq[0].brk, evq[0].ext, evq[0].with_pop} !== {8'h1C, 8'h61, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL single_event: code=%h asc=%h brk=%b ext=%b pop=%b required 1c 61 0 0 1",
                 evq[0].code, evq[0].ascii, evq[0].brk, evq[0].ext, evq[0].with_pop);
      end
    end
    checks++;
    if (pulses != 1 || bad_run) begin
      errors++; $display("FAIL single_pulse: pulses=%0d long=%0d required 1 0", pulses, bad_run);
    end
    checks++;
    if (key_held !== 1'b1 || key_count !== 8'd1) begin
      errors++; $display("FAIL single_state: held=%b cnt=%0d required 1 1", key_held, key_count);
    end
  endtask

  task automatic test_typematic();
    do_reset();
    fifo = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    drain();
    checks++;
    if (evq.size() != 2) begin
      errors++; $display("FAIL typ_evcount: got %0d required 2", evq.size());
    end else begin
      checks++;
      if (evq[0].brk !== 1'b0 || evq[1].brk !== 1'b1 || evq[1].code !== 8'h1C) begin
        errors++; $display("FAIL typ_events: brk0=%b brk1=%b code1=%h required 0 1 1c",
                           evq[0].brk, evq[1].brk, evq[1].code);
      end
    end
    checks++;
    if (key_count !== 8'd1 || key_held !== 1'b0) begin
      errors++; $display("FAIL typ_state: cnt=%0d held=%b required 1 0", key_count, key_held);
    end
    checks++;
    if (pulses != 5 || bad_run || min_gap < 3) begin
      errors++; $display("FAIL typ_pulses: pulses=%0d long=%0d gap=%0d required 5 0 >=3", pulses, bad_run, min_gap);
    end
  endtask

  task automatic test_extended();
    do_reset();
    fifo = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    drain();
    checks++;
    if (evq.size() != 2) begin
      errors++; $display("FAIL ext_evcount: got %0d required 2", evq.size());
    end else begin
      checks++;
      if ({evq[0].ext, evq[0].code, evq[0].ascii, evq[0].brk, evq[1].ext, evq[1].brk, evq[1].code}
          !== {1'b1, 8'h75, 8'h00, 1'b0, 1'b1, 1'b1, 8'h75}) begin
        errors++;
        $display("FAIL ext_events: ext0=%b code0=%h asc0=%h brk0=%b ext1=%b brk1=%b code1=%h required 1 75 00 0 1 1 75",
                 evq[0].ext, evq[0].code, evq[0].ascii, evq[0].brk, evq[1].ext, evq[1].brk, evq[1].code);
      end
    end
    checks++;
    if (key_count !== 8'd1 || key_held !== 1'b0) begin
      errors++; $display("FAIL ext_state: cnt=%0d held=%b required 1 0", key_count, key_held);
    end
  endtask

  task automatic test_multi_key();
    do_reset();
    fifo = '{8'h16, 8'h1E, 8'hF0, 8'h16};
    drain();
    checks++;
    if (evq.size() != 3) begin
      errors++; $display("FAIL multi_evcount: got %0d required 3", evq.size());
    end else begin
      checks++;
      if (evq[2].brk !== 1'b1 || evq[2].ascii !== 8'h31 || evq[2].code !== 8'h16) begin
        errors++; $display("FAIL multi_release: brk=%b asc=%h code=%h required 1 31 16",
                           evq[2].brk, evq[2].ascii, evq[2].code);
      end
    end
    checks++;
    if (key_count !== 8'd2 || key_held !== 1'b1) begin
      errors++; $display("FAIL multi_state: cnt=%0d held=%b required 2 1", key_count, key_held);
    end
    // 1E is still held: a repeat, then E0 1E is a distinct key.
    fifo = '{8'h1E, 8'hE0, 8'h1E};
    drain();
    checks++;
    if (evq.size() != 4 || key_count !== 8'd3) begin
      errors++; $display("FAIL multi_heldkey: events=%0d cnt=%0d required 4 3", evq.size(), key_count);
    end
  endtask

  task automatic test_prefix();
    do_reset();
    fifo = '{8'hE0, 8'hAA, 8'h5A, 8'hF0, 8'hE0, 8'h75};
    drain();
    checks++;
    if (evq.size() != 2) begin
      errors++; $display("FAIL prefix_evcount: got %0d required 2", evq.size());
    end else begin
      checks++;
      if ({evq[0].ext, evq[0].brk, evq[0].ascii, evq[1].ext, evq[1].brk, evq[1].code}
          !== {1'b0, 1'b0, 8'h0D, 1'b1, 1'b1, 8'h75}) begin
        errors++; $display("FAIL prefix_events: ext0=%b brk0=%b asc0=%h ext1=%b brk1=%b code1=%h required 0 0 0d 1 1 75",
                           evq[0].ext, evq[0].brk, evq[0].ascii, evq[1].ext, evq[1].brk, evq[1].code);
      end
    end
  endtask

  task automatic test_ascii();
    logic [7:0] codes [4];
    logic [7:0] exp_asc [4];
    codes   = '{8'h1A, 8'h45, 8'h66, 8'h0E};
    exp_asc = '{8'h7A, 8'h30, 8'h08, 8'h00};
    do_reset();
    for (int i = 0; i < 4; i++) fifo.push_back(codes[i]);
    drain();
    checks++;
    if (evq.size() != 4) begin
      errors++; $display("FAIL ascii_evcount: got %0d required 4", evq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (evq[i].ascii !== exp_asc[i]) begin
          errors++; $display("FAIL ascii_map: code=%h got %h required %h", codes[i], evq[i].ascii, exp_asc[i]);
        end
      end
    end
  endtask

  task automatic test_wrap_overflow();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      fifo.push_back(8'h29); fifo.push_back(8'hF0); fifo.push_back(8'h29);
    end
    drain();
    checks++;
    if (evq.size() != 512 || key_count !== 8'd0 || key_held !== 1'b0 || key_ascii !== 8'h20) begin
      errors++; $display("FAIL wrap_count: events=%0d cnt=%0d held=%b asc=%h required 512 0 0 20",
                         evq.size(), key_count, key_held, key_ascii);
    end
    checks++;
    if (overflow_seen !== 1'b0) begin
      errors++; $display("FAIL ovf_idle: got %b required 0", overflow_seen);
    end
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (overflow_seen !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b required 1", overflow_seen);
    end
    do_reset();
    checks++;
    if (overflow_seen !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b required 0", overflow_seen);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    fifo.push_back(8'h1C);
    drain();
    fifo.push_back(8'hF0);
    while (nextdata_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL midrst_pop: nextdata_n never low, got %b required 0", nextdata_n);
    end
    clrn = 1'b0;
    @(negedge clk);
    checks++;
    if ({nextdata_n, key_valid, key_code, key_held, key_count} !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00}) begin
      errors++; $display("FAIL midrst_values: ndn=%b kv=%b code=%h held=%b cnt=%0d required 1 0 00 0 0",
                         nextdata_n, key_valid, key_code, key_held, key_count);
    end
    clrn = 1'b1;
    @(negedge clk);
    evq.delete();
    fifo.push_back(8'h1C);
    drain();
    checks++;
    if (evq.size() != 1 || evq[0].brk !== 1'b0 || key_count !== 8'd1 || key_held !== 1'b1) begin
      errors++; $display("FAIL midrst_after: events=%0d cnt=%0d held=%b required 1 1 1",
                         evq.size(), key_count, key_held);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_typematic();
    test_extended();
    test_multi_key();
    test_prefix();
    test_ascii();
    test_wrap_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
